// File: rtl/mult_ctrl.sv
// mult_ctrl: sequencing controller and round-robin two-port arbiter for the
// WIDTH-bit shift-add multiplier datapath.
// Requests are granted round-robin. The granted operands are steered onto the
// datapath, its add/shift controls are sequenced, and the product is returned
// to the granted requester with a one-cycle done pulse.
// Optional feature: define MULT_EARLY_EXIT_EN to leave the add/shift loop as
// soon as the datapath reports that the multiplier has emptied.
module mult_ctrl #(
  parameter int WIDTH = 4
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               req0,
  input  logic               req1,
  input  logic [WIDTH-1:0]   a0,
  input  logic [WIDTH-1:0]   b0,
  input  logic [WIDTH-1:0]   a1,
  input  logic [WIDTH-1:0]   b1,
  output logic               done0,
  output logic               done1,
  output logic [2*WIDTH-1:0] result,
  output logic               busy,
  output logic [WIDTH-1:0]   a,
  output logic [WIDTH-1:0]   b,
  output logic               en_a,
  output logic               ld_shift_a,
  output logic               en_b,
  output logic               ld_shift_b,
  output logic               en_p,
  output logic               ld_add_p,
  output logic               valid,
  output logic [1:0]         state,
  input  logic               lsb_b,
  input  logic               zero,
  input  logic [2*WIDTH-1:0] product
);

  localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_ADD   = 2'b01,
    ST_SHIFT = 2'b10,
    ST_DONE  = 2'b11
  } state_t;

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               grant_q, grant_d;
  logic               last_grant_q, last_grant_d;
  logic               done0_q, done0_d;
  logic               done1_q, done1_d;
  logic [2*WIDTH-1:0] result_q, result_d;

  logic               elig0_s;
  logic               elig1_s;
  logic               any_elig_s;
  logic               win_s;
  logic               sel_s;

`ifndef MULT_EARLY_EXIT_EN
  // zero only steers the early exit; it is deliberately left unused here
  logic               unused_zero_s;
  assign unused_zero_s = zero;
`endif

  // Arbitration: a requester whose done is showing is masked so a held req
  // cannot reissue in the same cycle; ties go to the requester not served last.
  always_comb begin
    elig0_s    = req0 & ~done0_q;
    elig1_s    = req1 & ~done1_q;
    any_elig_s = elig0_s | elig1_s;
    if (elig0_s && elig1_s) begin
      win_s = ~last_grant_q;
    end else if (elig1_s) begin
      win_s = 1'b1;
    end else begin
      win_s = 1'b0;
    end
  end

  // Operand steering: live winner in IDLE (datapath loads every IDLE clock),
  // otherwise the latched grant.
  always_comb begin
    if (state_q == ST_IDLE) begin
      sel_s = any_elig_s ? win_s : 1'b0;
    end else begin
      sel_s = grant_q;
    end
    a = sel_s ? a1 : a0;
    b = sel_s ? b1 : b0;
  end

  // Next-state logic for the sequencer, grant bookkeeping and result capture.
  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    grant_d      = grant_q;
    last_grant_d = last_grant_q;
    done0_d      = 1'b0;
    done1_d      = 1'b0;
    result_d     = result_q;
    case (state_q)
      ST_IDLE: begin
        if (any_elig_s) begin
          grant_d      = win_s;
          last_grant_d = win_s;
          cnt_d        = {CNT_W{1'b0}};
          state_d      = ST_ADD;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_ADD: begin
`ifdef MULT_EARLY_EXIT_EN
        if (zero) begin
          state_d = ST_DONE;
        end else begin
          state_d = ST_SHIFT;
        end
`else
        state_d = ST_SHIFT;
`endif
      end
      ST_SHIFT: begin
        if (cnt_q == CNT_W'(WIDTH - 1)) begin
          state_d = ST_DONE;
        end else begin
          cnt_d   = cnt_q + CNT_W'(1);
          state_d = ST_ADD;
        end
      end
      ST_DONE: begin
        result_d = product;
        if (grant_q) begin
          done1_d = 1'b1;
        end else begin
          done0_d = 1'b1;
        end
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State-decoded datapath controls; everything is low unless a state asks.
  always_comb begin
    en_a       = 1'b0;
    ld_shift_a = 1'b0;
    en_b       = 1'b0;
    ld_shift_b = 1'b0;
    en_p       = 1'b0;
    ld_add_p   = 1'b0;
    valid      = 1'b0;
    case (state_q)
      ST_ADD: begin
        en_p     = lsb_b;
        ld_add_p = lsb_b;
      end
      ST_SHIFT: begin
        en_a       = 1'b1;
        ld_shift_a = 1'b1;
        en_b       = 1'b1;
        ld_shift_b = 1'b1;
      end
      ST_DONE: begin
        valid = 1'b1;
      end
      default: begin
        valid = 1'b0;
      end
    endcase
  end

  // Sequencer registers; reset aborts any operation without a done pulse.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q      <= ST_IDLE;
      cnt_q        <= {CNT_W{1'b0}};
      grant_q      <= 1'b0;
      last_grant_q <= 1'b1;
      done0_q      <= 1'b0;
      done1_q      <= 1'b0;
      result_q     <= {(2*WIDTH){1'b0}};
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      grant_q      <= grant_d;
      last_grant_q <= last_grant_d;
      done0_q      <= done0_d;
      done1_q      <= done1_d;
      result_q     <= result_d;
    end
  end

  assign done0  = done0_q;
  assign done1  = done1_q;
  assign result = result_q;
  assign busy   = (state_q != ST_IDLE);
  assign state  = state_q;

endmodule

// File: tb/tb_mult_ctrl.sv
// tb_mult_ctrl: self-checking bench for mult_ctrl. A small behavioural
// shift-add datapath closes the loop; expected grant order, done timing and
// products come from a transaction-level model of the arbitration rules.
module tb_mult_ctrl;

  localparam int WIDTH = 4;

  logic             clk;
  logic             reset;
  logic             req0, req1;
  logic [WIDTH-1:0] a0, b0, a1, b1;
  logic             done0, done1;
  logic [7:0]       result;
  logic             busy;
  logic [WIDTH-1:0] a, b;
  logic             en_a, ld_shift_a, en_b, ld_shift_b, en_p, ld_add_p, valid;
  logic [1:0]       state;
  logic             lsb_b, zero;
  logic [7:0]       product;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int add_cnt = 0;
  int valid_cnt = 0;
  bit m_last;

  mult_ctrl #(.WIDTH(WIDTH)) dut (
    .clk(clk), .reset(reset),
    .req0(req0), .req1(req1),
    .a0(a0), .b0(b0), .a1(a1), .b1(b1),
    .done0(done0), .done1(done1), .result(result), .busy(busy),
    .a(a), .b(b),
    .en_a(en_a), .ld_shift_a(ld_shift_a), .en_b(en_b), .ld_shift_b(ld_shift_b),
    .en_p(en_p), .ld_add_p(ld_add_p), .valid(valid), .state(state),
    .lsb_b(lsb_b), .zero(zero), .product(product)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Edge counter and per-transaction activity counters
  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (en_p && ld_add_p) add_cnt <= add_cnt + 1;
    if (valid) valid_cnt <= valid_cnt + 1;
  end

  // Behavioural shift-add datapath
  logic [7:0]       dp_a;
  logic [WIDTH-1:0] dp_b;
  logic [7:0]       dp_p;
  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      dp_a <= 8'd0; dp_b <= 4'd0; dp_p <= 8'd0;
    end else if (state == 2'b00) begin
      dp_a <= {4'd0, a}; dp_b <= b; dp_p <= 8'd0;
    end else begin
      if (en_p && ld_add_p) dp_p <= dp_p + dp_a;
      if (en_a && ld_shift_a) dp_a <= dp_a << 1;
      if (en_b && ld_shift_b) dp_b <= dp_b >> 1;
    end
  end
  assign lsb_b   = dp_b[0];
  assign zero    = (dp_b == 4'd0);
  assign product = dp_p;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Edges from E0 to the edge that raises done
  function automatic int lat(input logic [WIDTH-1:0] bv);
    int bl;
    bl = 0;
    for (int i = 0; i < WIDTH; i++) if (bv[i]) bl = i + 1;
`ifdef MULT_EARLY_EXIT_EN
    if (bl < WIDTH) return 2 * bl + 2;
`endif
    return 2 * WIDTH + 1;
  endfunction

  // Raise the given requests at a negedge, hold them for 'rounds' completions
  task automatic run_session(input bit r0, input bit r1, input int rounds);
    int e0, k, exp_d;
    logic [7:0] exp_p;
    logic [WIDTH-1:0] kb;
    e0 = cyc + 1;
    req0 = r0;
    req1 = r1;
    for (int n = 0; n < rounds; n++) begin
      k = (r0 && r1) ? (m_last ? 0 : 1) : (r1 ? 1 : 0);
      exp_p = (k == 1) ? ({4'd0, a1} * {4'd0, b1}) : ({4'd0, a0} * {4'd0, b0});
      kb = (k == 1) ? b1 : b0;
      exp_d = e0 + lat(kb);
      add_cnt = 0;
      valid_cnt = 0;
      if (n == 0) begin
        @(negedge clk);
        check_val("busy_after_e0", busy, 1);
        check_val("state_after_e0", state, 1);
      end
      do @(negedge clk); while (!(done0 || done1) && cyc < exp_d + 3);
      check_val("done_cycle", cyc, exp_d);
      check_val("done_who", {done1, done0}, (k == 1) ? 2 : 1);
      check_val("result", result, exp_p);
      check_val("busy_at_done", busy, 0);
      check_val("add_count", add_cnt, $countones(kb));
      check_val("valid_count", valid_cnt, 1);
      m_last = (k == 1);
      e0 = (r0 && r1) ? exp_d + 1 : exp_d + 2;
      if (n == rounds - 1) begin
        req0 = 1'b0;
        req1 = 1'b0;
      end
    end
    repeat (2) @(negedge clk);
    check_val("idle_no_done", {done1, done0}, 0);
    check_val("result_held", result, exp_p);
    check_val("idle_busy", busy, 0);
  endtask

  task automatic apply_reset();
    reset = 1'b0;
    repeat (2) @(negedge clk);
    reset = 1'b1;
    m_last = 1'b1;
  endtask

  initial begin
    int shifts;
    reset = 1'b0;
    req0 = 1'b0; req1 = 1'b0;
    a0 = 4'd0; b0 = 4'd0; a1 = 4'd0; b1 = 4'd0;
    m_last = 1'b1;
    repeat (3) @(negedge clk);
    check_val("rst_state", state, 0);
    check_val("rst_busy", busy, 0);
    check_val("rst_valid", valid, 0);
    check_val("rst_result", result, 0);
    check_val("rst_done", {done1, done0}, 0);
    reset = 1'b1;
    @(negedge clk);

    // Single requests
    a0 = 4'd3; b0 = 4'd5;
    run_session(1'b1, 1'b0, 1);
    a1 = 4'd15; b1 = 4'd15;
    run_session(1'b0, 1'b1, 1);

    // Simultaneous from reset, held: alternates 0,1,0,1
    apply_reset();
    a0 = 4'd7; b0 = 4'd2; a1 = 4'd4; b1 = 4'd9;
    run_session(1'b1, 1'b1, 4);

    // Zero multiplier and short multiplier
    a0 = 4'd9; b0 = 4'd0;
    run_session(1'b1, 1'b0, 1);
    a0 = 4'd6; b0 = 4'd2;
    run_session(1'b1, 1'b0, 1);

    // Reset during the third SHIFT cycle
    a0 = 4'd11; b0 = 4'd13;
    req0 = 1'b1;
    shifts = 0;
    for (int i = 0; i < 40 && shifts < 3; i++) begin
      @(negedge clk);
      if (state == 2'b10) shifts++;
    end
    check_val("third_shift_seen", shifts, 3);
    reset = 1'b0;
    #1;
    check_val("abort_state", state, 0);
    check_val("abort_busy", busy, 0);
    check_val("abort_valid", valid, 0);
    check_val("abort_result", result, 0);
    check_val("abort_done", {done1, done0}, 0);
    req0 = 1'b0;
    @(negedge clk);
    check_val("abort_no_done", {done1, done0}, 0);
    reset = 1'b1;
    m_last = 1'b1;
    run_session(1'b1, 1'b0, 1);

    // Randomized sessions
    for (int t = 0; t < 25; t++) begin
      int sel;
      a0 = 4'($urandom_range(0, 15));
      b0 = 4'($urandom_range(0, 15));
      a1 = 4'($urandom_range(0, 15));
      b1 = 4'($urandom_range(0, 15));
      sel = $urandom_range(1, 3);
      run_session(sel[0], sel[1], $urandom_range(1, 3));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
